mod_74x08_bist: RTL and testbench

Built-in self-test sequencer for a quad 2-input AND package (74x08 model: gates 1-4). It owns the A/B inputs of one package instance and walks a fixed 8-vector sequence. For each vector it waits a programmable settle time, samples Y and compares it against the expected AND result. It then reports per-gate pass/fail and the first failing vector. It sits between the package instance and system control, and is used for power-on check and for fault-injection benches.

---
 rtl/mod_74x08_bist.sv | 160 ++++++++++++++++
 tb/tb_mod_74x08_bist.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mod_74x08_bist.sv
// Built-in self-test sequencer for one quad 2-input AND package (74x08).
// Walks eight fixed A/B vectors, samples Y after a settle time, reports per-gate failures.
module mod_74x08_bist #(
  parameter int SETTLE = 2
) (
  input  logic       CLK,
  input  logic       CLR_n,
  input  logic       START,
  output logic [3:0] A,
  output logic [3:0] B,
  input  logic [3:0] Y,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [3:0] FAIL_MASK,
  output logic [2:0] FAIL_VEC
);

  localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [SW-1:0] S_MAX = SW'(SETTLE);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t        state_q, state_d;
  logic [2:0]    v_q, v_d;
  logic [SW-1:0] s_q, s_d;
  logic [3:0]    a_q, a_d;
  logic [3:0]    b_q, b_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic [3:0]    fail_mask_q, fail_mask_d;
  logic [2:0]    fail_vec_q, fail_vec_d;
  logic          failed_q, failed_d;
  logic [3:0]    err;

  // Vectors 0-3 exercise all gates together; 4-7 walk a single one across gates.
  function automatic logic [3:0] one_hot(input logic [1:0] k);
    return 4'b0001 << k;
  endfunction

  function automatic logic [3:0] vec_a(input logic [2:0] v);
    case (v)
      3'd0, 3'd2: return 4'b1111;
      3'd1, 3'd3: return 4'b0000;
      default:    return one_hot(v[1:0]);
    endcase
  endfunction

  function automatic logic [3:0] vec_b(input logic [2:0] v);
    case (v)
      3'd0, 3'd1: return 4'b1111;
      3'd2, 3'd3: return 4'b0000;
      default:    return one_hot(v[1:0]);
    endcase
  endfunction

  function automatic logic [3:0] vec_exp(input logic [2:0] v);
    return vec_a(v) & vec_b(v);
  endfunction

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d     = state_q;
    v_d         = v_q;
    s_d         = s_q;
    a_d         = a_q;
    b_d         = b_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    fail_mask_d = fail_mask_q;
    fail_vec_d  = fail_vec_q;
    failed_d    = failed_q;
    err         = 4'b0000;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (START) begin
          state_d     = ST_RUN;
          v_d         = 3'd0;
          s_d         = '0;
          a_d         = vec_a(3'd0);
          b_d         = vec_b(3'd0);
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          fail_mask_d = 4'b0000;
          fail_vec_d  = 3'd0;
          failed_d    = 1'b0;
        end
      end
      ST_RUN: begin
        if (s_q != S_MAX) begin
          s_d = s_q + SW'(1);
        end else begin
          err         = Y ^ vec_exp(v_q);
          fail_mask_d = fail_mask_q | err;
          // failed_q distinguishes "first failure at vector 0" from "no failure".
          if (err != 4'b0000 && !failed_q) begin
            fail_vec_d = v_q;
            failed_d   = 1'b1;
          end
          if (v_q != 3'd7) begin
            v_d = v_q + 3'd1;
            s_d = '0;
            a_d = vec_a(v_q + 3'd1);
            b_d = vec_b(v_q + 3'd1);
          end else begin
            a_d     = 4'b0000;
            b_d     = 4'b0000;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (fail_mask_d == 4'b0000);
            state_d = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge CLK or negedge CLR_n) begin
    if (!CLR_n) begin
      state_q     <= ST_IDLE;
      v_q         <= 3'd0;
      s_q         <= '0;
      a_q         <= 4'b0000;
      b_q         <= 4'b0000;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_mask_q <= 4'b0000;
      fail_vec_q  <= 3'd0;
      failed_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      v_q         <= v_d;
      s_q         <= s_d;
      a_q         <= a_d;
      b_q         <= b_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_mask_q <= fail_mask_d;
      fail_vec_q  <= fail_vec_d;
      failed_q    <= failed_d;
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign PASS      = pass_q;
  assign FAIL_MASK = fail_mask_q;
  assign FAIL_VEC  = fail_vec_q;

endmodule

// File: tb/tb_mod_74x08_bist.sv
// Scoreboard bench for mod_74x08_bist: a faultable 74x08 model feeds Y, runs are
// queued with hand-computed results and checked by monitors when DONE rises.
module tb_mod_74x08_bist;

  typedef struct {
    int         busy;
    logic       pass;
    logic [3:0] mask;
    logic [2:0] vec;
  } result_t;

  logic       clk, rst_n;
  logic       start, start0;
  logic [3:0] a, b, y, a0, b0, y0;
  logic       busy, done, pass, busy0, done0, pass0;
  logic [3:0] fail_mask, fail_mask0;
  logic [2:0] fail_vec, fail_vec0;
  int         fault;

  result_t q[$];
  result_t q0[$];
  int      n_total = 0;
  int      n_pass  = 0;

  mod_74x08_bist #(.SETTLE(2)) u_dut (
    .CLK(clk), .CLR_n(rst_n), .START(start), .A(a), .B(b), .Y(y),
    .BUSY(busy), .DONE(done), .PASS(pass), .FAIL_MASK(fail_mask), .FAIL_VEC(fail_vec)
  );

  mod_74x08_bist #(.SETTLE(0)) u_dut0 (
    .CLK(clk), .CLR_n(rst_n), .START(start0), .A(a0), .B(b0), .Y(y0),
    .BUSY(busy0), .DONE(done0), .PASS(pass0), .FAIL_MASK(fail_mask0), .FAIL_VEC(fail_vec0)
  );

  // Package model: 0 golden, 1 Y3 stuck-at-0, 2 Y1 stuck-at-1, 3 bridge Y2 := Y2|Y1.
  always_comb begin
    y = a & b;
    case (fault)
      1: y[2] = 1'b0;
      2: y[0] = 1'b1;
      3: y[1] = (a[1] & b[1]) | (a[0] & b[0]);
      default: ;
    endcase
  end
  assign y0 = a0 & b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic compare(input string tag, input result_t e, input int busy_cnt,
                         input logic pass_a, input logic [3:0] mask_a, input logic [2:0] vec_a,
                         input logic [3:0] a_a, input logic [3:0] b_a, input logic busy_a);
    check({tag, "_busy_cycles"}, busy_cnt, e.busy);
    check({tag, "_pass"}, pass_a, e.pass);
    check({tag, "_fail_mask"}, mask_a, e.mask);
    check({tag, "_fail_vec"}, vec_a, e.vec);
    check({tag, "_ab_idle"}, {a_a, b_a}, 8'h00);
    check({tag, "_busy_low"}, busy_a, 1'b0);
  endtask

  // Monitor for the SETTLE=2 instance.
  int   busy_cnt = 0;
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    result_t e;
    if (!rst_n) begin
      busy_cnt  = 0;
      done_prev = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (done && !done_prev) begin
        if (q.size() == 0) check("unexpected_done", 1, 0);
        else begin
          e = q.pop_front();
          compare("s2", e, busy_cnt, pass, fail_mask, fail_vec, a, b, busy);
        end
        busy_cnt = 0;
      end
      done_prev = done;
    end
  end

  // Monitor for the SETTLE=0 instance.
  int   busy_cnt0 = 0;
  logic done_prev0 = 1'b0;
  always @(negedge clk) begin
    result_t e;
    if (!rst_n) begin
      busy_cnt0  = 0;
      done_prev0 = 1'b0;
    end else begin
      if (busy0) busy_cnt0++;
      if (done0 && !done_prev0) begin
        if (q0.size() == 0) check("unexpected_done0", 1, 0);
        else begin
          e = q0.pop_front();
          compare("s0", e, busy_cnt0, pass0, fail_mask0, fail_vec0, a0, b0, busy0);
        end
        busy_cnt0 = 0;
      end
      done_prev0 = done0;
    end
  end

  task automatic wait_done(input bit sel);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sel ? done0 : done) return;
    end
    check(sel ? "done0_timeout" : "done_timeout", 0, 1);
  endtask

  task automatic run(input int f, input result_t e);
    @(negedge clk);
    fault = f;
    start = 1'b1;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ab"}, {a, b}, 8'h00);
    check({tag, "_flags"}, {busy, done, pass}, 3'b000);
    check({tag, "_mask_vec"}, {fail_mask, fail_vec}, 7'h00);
  endtask

  localparam result_t GOLD   = '{busy: 24, pass: 1'b1, mask: 4'b0000, vec: 3'd0};
  localparam result_t Y3_SA0 = '{busy: 24, pass: 1'b0, mask: 4'b0100, vec: 3'd0};
  localparam result_t Y1_SA1 = '{busy: 24, pass: 1'b0, mask: 4'b0001, vec: 3'd1};
  localparam result_t BRIDGE = '{busy: 24, pass: 1'b0, mask: 4'b0010, vec: 3'd4};
  localparam result_t GOLD0  = '{busy: 8,  pass: 1'b1, mask: 4'b0000, vec: 3'd0};

  initial begin
    fault  = 0;
    start  = 1'b0;
    start0 = 1'b0;
    rst_n  = 1'b1;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    check("reset0_flags", {busy0, done0, pass0, fail_mask0, fail_vec0}, 10'h000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Functional runs on the SETTLE=2 instance.
    run(0, GOLD);
    run(1, Y3_SA0);
    run(3, BRIDGE);
    run(2, Y1_SA1);

    // START while in DONE: results clear on that edge and vector 0 is applied.
    @(negedge clk);
    fault = 0;
    start = 1'b1;
    q.push_back(GOLD);
    @(negedge clk);
    start = 1'b0;
    check("restart_flags", {busy, done, pass}, 3'b100);
    check("restart_cleared", {fail_mask, fail_vec}, 7'h00);
    check("restart_vec0_ab", {a, b}, 8'hFF);
    wait_done(1'b0);

    // START pulsed mid-run is ignored; busy length stays 24.
    @(negedge clk);
    start = 1'b1;
    q.push_back(GOLD);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(1'b0);

    // SETTLE=0 instance: DONE exactly 8 cycles after START.
    @(negedge clk);
    start0 = 1'b1;
    q0.push_back(GOLD0);
    @(negedge clk);
    start0 = 1'b0;
    wait_done(1'b1);

    // Asynchronous clear at cycle 10 of a faulty run, between clock edges.
    @(negedge clk);
    fault = 2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 check("pre_clear_mask", fail_mask, 4'b0001);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("async_clear");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(0, GOLD);

    for (int i = 0; i < 50 && (q.size() + q0.size()) != 0; i++) @(negedge clk);
    check("scoreboard_drain", q.size() + q0.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
